seven_seg_scan: RTL and testbench
=================================

// Module: seven_seg_scan
// PURPOSE
//  Time-multiplexed 8-digit seven-segment driver; consumes the 32-bit debug_output word from the top level.
//  Latches the word into a tear-free shadow register, scans one hex nibble per digit slot and drives
//  active-low anode/segment pins. Adds inter-digit ghost blanking and optional leading-zero suppression.
//  Sits directly downstream of the debug_output mux, on the 100 MHz board clock.
// PARAMETERS
//  REFRESH_DIV   50000  clk cycles per digit slot (>=1)
//  BLANK_CYCLES  64     cycles at slot start with all anodes off (0 = disabled; must be < REFRESH_DIV)
// PORTS
//  clk          in   1   board clock; all logic on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  data_in      in   32  word to display; nibble k shown on digit k (digit 0 = data_in[3:0])
//  load         in   1   capture data_in into the shadow register on this edge, mid-frame
//  hold         in   1   1 = freeze the shadow register (no frame-start capture)
//  lz_blank     in   1   1 = blank leading-zero digits
//  an           out  8   anode enables, active-low, one-hot-low when lit
//  sev_out      out  7   segments {a,b,c,d,e,f,g}, active-low; 0->7'b0000001 ... F->7'b0111000
//  digit_idx    out  3   index of the current slot
//  frame_done   out  1   one-cycle pulse when the slot index wraps 7->0
// BEHAVIOUR
//  Reset (async assert, sync-free release): prescaler=0, digit_idx=0, shadow=0, an=8'hFF,
//   sev_out=7'h7F, frame_done=0. Assertion mid-scan forces these values immediately.
//  Prescaler counts 0..REFRESH_DIV-1 and wraps. tick = (prescaler==REFRESH_DIV-1).
//   REFRESH_DIV=1 gives tick every cycle.
//  On tick: digit_idx <= digit_idx+1 (mod 8). frame_done is high for the cycle after the edge where 7->0.
//  Shadow capture, priority order:
//   1. load=1 -> shadow<=data_in. load beats hold.
//   2. Otherwise, on the tick edge where digit_idx goes 7->0 and hold=0 -> shadow<=data_in.
//   3. Otherwise shadow holds.
//   Frame-start capture and load in the same cycle both take the current data_in.
//  Slot timing: slot_cnt = prescaler value.
//   an/sev_out are registered and updated every edge from the NEXT digit_idx/prescaler state,
//   so outputs change on the same edge as digit_idx (zero added latency).
//   A shadow capture appears on outputs no later than the next edge.
//   While slot_cnt < BLANK_CYCLES: an=8'hFF, sev_out=7'h7F.
//   Otherwise: an=~(8'b1<<digit_idx), sev_out=hex decode of shadow[4*digit_idx+:4].
//  Leading-zero blanking (lz_blank=1): msd = index of the highest nonzero nibble of shadow (0 if shadow==0).
//   Digits with index > msd are blanked (an bit high, sev_out=7'h7F) for the whole slot.
//   Digit 0 is never suppressed, so 0 shows as "0".
//  lz_blank, hold and data_in are sampled synchronously; changes affect at most the next edge.
//  No combinational path from any input to an/sev_out.
// TESTING (bench uses REFRESH_DIV=4, BLANK_CYCLES=1)
//  1 Reset: rst_n low mid-scan for 1 ns between edges -> an=FF, sev_out=7F, digit_idx=0 immediately;
//    first lit digit 1 cycle after release.
//  2 Scan: data_in=32'h76543210, lz_blank=0 -> digit k lit for 3 of 4 cycles, an=~(1<<k),
//    sev_out decodes k. frame_done pulses every 32 cycles.
//  3 Tear-free: change data_in 32'h11111111->32'h22222222 mid-frame -> all digits keep 1 until the
//    next frame, then all show 2.
//  4 load/hold: hold=1, pulse load with data_in=32'hDEADBEEF mid-frame -> next edge shadow=DEADBEEF.
//    Later data_in changes are ignored across frames while hold=1.
//  5 Leading zeros: lz_blank=1, data_in=32'h000000A5 -> digits 0,1 show 5,A; digits 2-7 have an bit high.
//    data_in=0 -> only digit 0 lit, showing "0".
//  6 Edge params: REFRESH_DIV=1, BLANK_CYCLES=0 -> digit advances every cycle, no blank cycles,
//    frame_done every 8 cycles.

Source files
------------

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed 8-digit seven-segment driver.
// Latches a 32-bit word into a tear-free shadow register and scans one hex
// nibble per digit slot onto active-low anode/segment pins, with inter-digit
// ghost blanking and optional leading-zero suppression. All outputs are
// registered; they are computed from the next-state values so they change on
// the same edge as digit_idx.
module seven_seg_scan #(
    parameter int REFRESH_DIV  = 50000,  // clk cycles per digit slot (>= 1)
    parameter int BLANK_CYCLES = 64      // dark cycles at slot start (< REFRESH_DIV)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_in,
    input  logic        load,
    input  logic        hold,
    input  logic        lz_blank,
    output logic [7:0]  an,
    output logic [6:0]  sev_out,
    output logic [2:0]  digit_idx,
    output logic        frame_done
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [PW-1:0] prescaler;
    logic [PW-1:0] prescaler_nxt;
    logic [2:0]    digit_nxt;
    logic [31:0]   shadow;
    logic [31:0]   shadow_nxt;
    logic          tick;
    logic          wrap;
    logic          blank_nxt;
    logic [2:0]    msd;
    logic [7:0]    an_nxt;
    logic [6:0]    sev_nxt;

    // Hex nibble to active-low {a,b,c,d,e,f,g}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    // Slot timing and next scan position.
    always_comb begin
        tick          = (prescaler == PW'(REFRESH_DIV - 1));
        wrap          = tick && (digit_idx == 3'd7);
        prescaler_nxt = tick ? '0 : prescaler + PW'(1);
        digit_nxt     = tick ? digit_idx + 3'd1 : digit_idx;
    end

    // Shadow capture: explicit load wins over hold; otherwise refresh at frame start.
    always_comb begin
        if (load)
            shadow_nxt = data_in;
        else if (wrap && !hold)
            shadow_nxt = data_in;
        else
            shadow_nxt = shadow;
    end

    // Ghost blanking window at the start of every slot (absent when BLANK_CYCLES is 0).
    if (BLANK_CYCLES == 0) begin : g_no_blank
        assign blank_nxt = 1'b0;
    end else begin : g_blank
        assign blank_nxt = (prescaler_nxt < PW'(BLANK_CYCLES));
    end

    // Most significant nonzero nibble of the word about to be displayed.
    always_comb begin
        msd = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (shadow_nxt[4*k +: 4] != 4'h0)
                msd = 3'(k);
        end
    end

    // Next anode/segment pattern; digit 0 is never suppressed since msd >= 0.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        an_nxt  = 8'hFF;
        sev_nxt = 7'h7F;
        if (!blank_nxt && !(lz_blank && (digit_nxt > msd))) begin
            an_nxt  = ~(8'b1 << digit_nxt);
            sev_nxt = hex_to_seg(shadow_nxt[{digit_nxt, 2'b00} +: 4]);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler  <= '0;
            digit_idx  <= 3'd0;
            // NOTE: the shadow is a plain register, not a memory, so it is cleared by reset like any other state.
            shadow     <= 32'h0;
            an         <= 8'hFF;
            sev_out    <= 7'h7F;
            frame_done <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            prescaler  <= prescaler_nxt;
            digit_idx  <= digit_nxt;
            shadow     <= shadow_nxt;
            an         <= an_nxt;
            sev_out    <= sev_nxt;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan: a spec-level model pushes expected
// outputs into a scoreboard queue before each edge; they are popped and
// compared one nanosecond after the edge. Scenario tasks add targeted checks.
`timescale 1ns/100ps
module tb_seven_seg_scan;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] sev;
        logic [2:0] dig;
        logic       fd;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] data_in;
    logic        load;
    logic        hold;
    logic        lz_blank;
    logic [7:0]  an,   an_e;
    logic [6:0]  sev_out, sev_e;
    logic [2:0]  digit_idx, digit_e;
    logic        frame_done, frame_done_e;

    int pass_cnt  = 0;
    int check_cnt = 0;
    int cyc       = 0;

    // Model state for the main instance (REFRESH_DIV=4, BLANK_CYCLES=1).
    int          m_pre;
    logic [2:0]  m_dig;
    logic [31:0] m_sh;
    exp_t        sb_q[$];

    seven_seg_scan #(.REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load), .hold(hold),
        .lz_blank(lz_blank), .an(an), .sev_out(sev_out), .digit_idx(digit_idx),
        .frame_done(frame_done)
    );

    seven_seg_scan #(.REFRESH_DIV(1), .BLANK_CYCLES(0)) dut_e (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load), .hold(hold),
        .lz_blank(lz_blank), .an(an_e), .sev_out(sev_e), .digit_idx(digit_e),
        .frame_done(frame_done_e)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] seg(input logic [3:0] n);
        logic [6:0] tab [16];
        tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        return tab[n];
    endfunction

    function automatic logic [3:0] nib(input logic [31:0] w, input logic [2:0] k);
        return 4'((w >> (4 * int'(k))) & 32'hF);
    endfunction

    task automatic model_reset();
        m_pre = 0;
        m_dig = 3'd0;
        m_sh  = 32'h0;
        sb_q.delete();
    endtask

    // One clock: model predicts, DUT clocks, scoreboard compares.
    task automatic step();
        exp_t        e;
        bit          tk;
        int          n_pre;
        logic [2:0]  n_dig;
        logic [31:0] n_sh;
        int          top;
        tk    = (m_pre == 3);
        n_pre = tk ? 0 : m_pre + 1;
        n_dig = tk ? m_dig + 3'd1 : m_dig;
        if (load)                             n_sh = data_in;
        else if (tk && m_dig == 3'd7 && !hold) n_sh = data_in;
        else                                  n_sh = m_sh;
        top = 0;
        for (int k = 0; k < 8; k++)
            if (nib(n_sh, 3'(k)) != 4'h0) top = k;
        e.dig = n_dig;
        e.fd  = tk && (m_dig == 3'd7);
        if (n_pre < 1 || (lz_blank && int'(n_dig) > top)) begin
            e.an  = 8'hFF;
            e.sev = 7'h7F;
        end else begin
            e.an  = ~(8'b1 << n_dig);
            e.sev = seg(nib(n_sh, n_dig));
        end
        sb_q.push_back(e);
        m_pre = n_pre;
        m_dig = n_dig;
        m_sh  = n_sh;
        @(posedge clk);
        #1;
        cyc++;
        e = sb_q.pop_front();
        check_cnt++;
        if ({an, sev_out, digit_idx, frame_done} !== e)
            $display("FAIL scoreboard cyc=%0d got an=%h sev=%b dig=%0d fd=%b expected an=%h sev=%b dig=%0d fd=%b",
                     cyc, an, sev_out, digit_idx, frame_done, e.an, e.sev, e.dig, e.fd);
        else
            pass_cnt++;
    endtask

    // Step until frame_done is seen (bounded).
    task automatic run_until_fd(input int max_cyc);
        int n = 0;
        do begin
            step();
            n++;
        end while (frame_done !== 1'b1 && n < max_cyc);
        check_cnt++;
        if (frame_done !== 1'b1) $display("FAIL frame_wait timeout after %0d cycles", n);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        repeat (6) step();
        #2 rst_n = 1'b0;
        #1;
        check_cnt++;
        if ({an, sev_out, digit_idx, frame_done} !== {8'hFF, 7'h7F, 3'd0, 1'b0})
            $display("FAIL reset_async got an=%h sev=%h dig=%0d fd=%b required an=ff sev=7f dig=0 fd=0",
                     an, sev_out, digit_idx, frame_done);
        else pass_cnt++;
        check_cnt++;
        if ({an_e, sev_e, digit_e} !== {8'hFF, 7'h7F, 3'd0})
            $display("FAIL reset_async_edge got an=%h sev=%h dig=%0d required an=ff sev=7f dig=0", an_e, sev_e, digit_e);
        else pass_cnt++;
        rst_n = 1'b1;
        model_reset();
        step();
        check_cnt++;
        if (an !== 8'hFE || sev_out !== seg(4'h0))
            $display("FAIL reset_first_lit got an=%h sev=%b required an=fe sev=%b", an, sev_out, seg(4'h0));
        else pass_cnt++;
    endtask

    task automatic test_scan();
        int lit [8];
        int bad_seg = 0;
        int fd_cyc[$];
        data_in = 32'h76543210;
        load = 1'b1;
        step();
        load = 1'b0;
        foreach (lit[k]) lit[k] = 0;
        repeat (64) begin
            step();
            for (int k = 0; k < 8; k++)
                if (an === ~(8'b1 << k)) begin
                    lit[k]++;
                    if (sev_out !== seg(4'(k))) bad_seg++;
                end
            if (frame_done === 1'b1) fd_cyc.push_back(cyc);
        end
        for (int k = 0; k < 8; k++) begin
            check_cnt++;
            if (lit[k] !== 6) $display("FAIL scan_lit digit=%0d got %0d lit cycles required 6", k, lit[k]);
            else pass_cnt++;
        end
        check_cnt++;
        if (bad_seg !== 0) $display("FAIL scan_decode got %0d wrong segment cycles required 0", bad_seg);
        else pass_cnt++;
        check_cnt++;
        if (fd_cyc.size() !== 2 || (fd_cyc[1] - fd_cyc[0]) !== 32)
            $display("FAIL scan_frame_period got %0d pulses required 2 pulses 32 apart", fd_cyc.size());
        else pass_cnt++;
    endtask

    task automatic test_tear_free();
        int old_bad = 0, new_bad = 0, new_lit = 0;
        data_in = 32'h11111111;
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (10) step();
        data_in = 32'h22222222;
        do begin
            step();
            if (an !== 8'hFF && sev_out !== seg(4'h1)) old_bad++;
        end while (frame_done !== 1'b1 && cyc < 90000);
        repeat (32) begin
            step();
            if (an !== 8'hFF) begin
                new_lit++;
                if (sev_out !== seg(4'h2)) new_bad++;
            end
        end
        check_cnt++;
        if (old_bad !== 0) $display("FAIL tear_old_frame got %0d cycles not showing 1 required 0", old_bad);
        else pass_cnt++;
        check_cnt++;
        if (new_bad !== 0 || new_lit !== 24)
            $display("FAIL tear_new_frame got bad=%0d lit=%0d required bad=0 lit=24", new_bad, new_lit);
        else pass_cnt++;
    endtask

    task automatic test_load_hold();
        int bad = 0;
        hold = 1'b1;
        repeat (5) step();
        data_in = 32'hDEADBEEF;
        load = 1'b1;
        step();
        load = 1'b0;
        data_in = 32'h12345678;
        run_until_fd(40);
        data_in = 32'h0F0F0F0F;
        repeat (40) begin
            step();
            if (an !== 8'hFF && sev_out !== seg(nib(32'hDEADBEEF, digit_idx))) bad++;
        end
        check_cnt++;
        if (bad !== 0) $display("FAIL load_hold got %0d cycles not showing DEADBEEF required 0", bad);
        else pass_cnt++;
        hold = 1'b0;
    endtask

    task automatic test_leading_zero();
        int lit [8];
        int bad = 0;
        lz_blank = 1'b1;
        data_in  = 32'h000000A5;
        run_until_fd(40);
        foreach (lit[k]) lit[k] = 0;
        repeat (32) begin
            step();
            for (int k = 0; k < 8; k++) if (an === ~(8'b1 << k)) lit[k]++;
            if (an === 8'hFE && sev_out !== seg(4'h5)) bad++;
            if (an === 8'hFD && sev_out !== seg(4'hA)) bad++;
        end
        check_cnt++;
        if (lit[0] !== 3 || lit[1] !== 3 || bad !== 0)
            $display("FAIL lz_a5_low got lit0=%0d lit1=%0d bad=%0d required 3 3 0", lit[0], lit[1], bad);
        else pass_cnt++;
        check_cnt++;
        if ((lit[2] + lit[3] + lit[4] + lit[5] + lit[6] + lit[7]) !== 0)
            $display("FAIL lz_a5_high got %0d lit cycles on digits 2-7 required 0",
                     lit[2] + lit[3] + lit[4] + lit[5] + lit[6] + lit[7]);
        else pass_cnt++;
        data_in = 32'h0;
        run_until_fd(40);
        foreach (lit[k]) lit[k] = 0;
        bad = 0;
        repeat (32) begin
            step();
            if (an !== 8'hFF && an !== 8'hFE) bad++;
            if (an === 8'hFE) begin
                lit[0]++;
                if (sev_out !== seg(4'h0)) bad++;
            end
        end
        check_cnt++;
        if (lit[0] !== 3 || bad !== 0)
            $display("FAIL lz_zero got lit0=%0d bad=%0d required 3 0", lit[0], bad);
        else pass_cnt++;
        lz_blank = 1'b0;
    endtask

    task automatic test_edge_params();
        int          fd_n = 0, bad = 0;
        logic [2:0]  prev;
        data_in = 32'h89ABCDEF;
        repeat (9) step();
        prev = digit_e;
        repeat (24) begin
            step();
            if (digit_e !== prev + 3'd1) bad++;
            if (an_e !== ~(8'b1 << digit_e)) bad++;
            if (sev_e !== seg(nib(32'h89ABCDEF, digit_e))) bad++;
            if (frame_done_e !== (digit_e == 3'd0)) bad++;
            if (frame_done_e === 1'b1) fd_n++;
            prev = digit_e;
        end
        check_cnt++;
        if (bad !== 0) $display("FAIL edge_scan got %0d bad cycles required 0", bad);
        else pass_cnt++;
        check_cnt++;
        if (fd_n !== 3) $display("FAIL edge_frame_done got %0d pulses in 24 cycles required 3", fd_n);
        else pass_cnt++;
    endtask

    initial begin
        rst_n    = 1'b0;
        data_in  = 32'h0;
        load     = 1'b0;
        hold     = 1'b0;
        lz_blank = 1'b0;
        model_reset();
        #12 rst_n = 1'b1;
        test_reset();
        test_scan();
        test_tear_free();
        test_load_hold();
        test_leading_zero();
        test_edge_params();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
